// File: rtl/axis_decimator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_decimator
//
// Decimate-by-DECIM stage placed after the low-pass FIR of the CSI extractor.
// One of every DECIM accepted input samples is kept. Kept samples are
// width-converted to the output width and tagged with tlast every FRAME_LEN
// outputs so the next stage receives FFT-sized frames. A 2-entry output
// buffer absorbs downstream backpressure.
//
// Parameters
//   C_S_AXIS_TDATA_WIDTH  input sample width (signed)
//   C_M_AXIS_TDATA_WIDTH  output sample width (signed)
//   DECIM                 decimation ratio, >= 1 (1 passes every sample)
//   FRAME_LEN             output samples per frame, >= 1
//
// Ports
//   aclk                clock, all logic on its rising edge
//   areset              synchronous reset, active-high
//   s_axis_data_tvalid  input sample valid
//   s_axis_data_tdata   signed input sample
//   s_axis_data_tready  input ready (registered state plus phase_sync)
//   phase_sync          sampled on an input handshake; realigns phase/frame
//   m_axis_data_tready  downstream ready
//   m_axis_data_tvalid  output valid (buffer not empty)
//   m_axis_data_tdata   signed decimated sample (buffer head)
//   m_axis_data_tlast   last sample of a frame (buffer head)
//   sat_flag            sticky, a kept sample was clipped since reset
// -----------------------------------------------------------------------------
module axis_decimator #(
  parameter int C_S_AXIS_TDATA_WIDTH = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 16,
  parameter int DECIM                = 6,
  parameter int FRAME_LEN            = 64
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axis_data_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_data_tdata,
  output logic                            s_axis_data_tready,
  input  logic                            phase_sync,
  input  logic                            m_axis_data_tready,
  output logic                            m_axis_data_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                            m_axis_data_tlast,
  output logic                            sat_flag
);

  localparam int SW = C_S_AXIS_TDATA_WIDTH;
  localparam int MW = C_M_AXIS_TDATA_WIDTH;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [PW-1:0] PHASE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  // After a sync beat the next sample is phase 1, except when every sample is kept.
  localparam logic [PW-1:0] PHASE_AFTER_SYNC = (DECIM == 1) ? {PW{1'b0}} : PW'(1);
  localparam logic [FW-1:0] FRAME_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          areset_q_r;
  logic [PW-1:0] phase_r;
  logic [FW-1:0] frame_r;
  logic [1:0]    occ_r;
  logic [MW-1:0] head_data_r;
  logic          head_last_r;
  logic [MW-1:0] tail_data_r;
  logic          tail_last_r;
  logic          sat_r;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic          ready_s;
  logic          acc_s;
  logic          keep_s;
  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] phase_nxt_s;
  logic [FW-1:0] frame_idx_s;
  logic          last_s;
  logic [FW-1:0] frame_nxt_s;
  logic [MW-1:0] conv_data_s;
  logic          conv_sat_s;
  logic [1:0]    occ_nxt_s;
  logic [MW-1:0] head_data_nxt_s;
  logic          head_last_nxt_s;
  logic [MW-1:0] tail_data_nxt_s;
  logic          tail_last_nxt_s;
  logic          sat_nxt_s;

  // Delayed reset copy; keeps tready low for one cycle after reset release.
  always_ff @(posedge aclk) begin
    areset_q_r <= areset;
  end

  // Input ready. Discarded beats (phase != 0) are never stalled while the
  // buffer is full, but a sync beat would be kept, so it must wait then.
  always_comb begin
    if (areset_q_r) begin
      ready_s = 1'b0;
    end else if (occ_r != 2'd2) begin
      ready_s = 1'b1;
    end else if ((phase_r != PHASE_ZERO) && !phase_sync) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Handshakes and the keep decision.
  always_comb begin
    acc_s  = s_axis_data_tvalid && ready_s;
    keep_s = (phase_r == PHASE_ZERO) || phase_sync;
    push_s = acc_s && keep_s;
    pop_s  = (occ_r != 2'd0) && m_axis_data_tready;
  end

  // Decimation phase: sync restarts the count with this beat as phase 0.
  always_comb begin
    phase_nxt_s = phase_r;
    if (!acc_s) begin
      phase_nxt_s = phase_r;
    end else if (phase_sync) begin
      phase_nxt_s = PHASE_AFTER_SYNC;
    end else if (phase_r == PHASE_LAST) begin
      phase_nxt_s = PHASE_ZERO;
    end else begin
      phase_nxt_s = phase_r + PW'(1);
    end
  end

  // Frame position of the kept sample; sync forces index 0 for this beat.
  always_comb begin
    frame_idx_s = phase_sync ? FRAME_ZERO : frame_r;
    last_s      = (frame_idx_s == FRAME_LAST);
    frame_nxt_s = frame_r;
    if (!push_s) begin
      frame_nxt_s = frame_r;
    end else if (last_s) begin
      frame_nxt_s = FRAME_ZERO;
    end else begin
      frame_nxt_s = frame_idx_s + FW'(1);
    end
  end

  // Width conversion: sign-extend when widening, saturate when narrowing.
  if (MW >= SW) begin : g_extend
    // Widening (or equal width) cannot clip.
    always_comb begin
      conv_data_s = MW'($signed(s_axis_data_tdata));
      conv_sat_s  = 1'b0;
    end
  end else begin : g_saturate
    logic [SW-MW:0] top_s;
    // The sample fits iff the dropped bits and the new sign bit all agree.
    always_comb begin
      top_s = s_axis_data_tdata[SW-1:MW-1];
      if ((&top_s) || !(|top_s)) begin
        conv_data_s = s_axis_data_tdata[MW-1:0];
        conv_sat_s  = 1'b0;
      end else if (s_axis_data_tdata[SW-1]) begin
        conv_data_s = {1'b1, {(MW-1){1'b0}}};
        conv_sat_s  = 1'b1;
      end else begin
        conv_data_s = {1'b0, {(MW-1){1'b1}}};
        conv_sat_s  = 1'b1;
      end
    end
  end

  // Two-entry output buffer. The head register drives m_axis directly, so
  // it only changes on a pop or when a push lands in an empty buffer.
  always_comb begin
    occ_nxt_s       = occ_r;
    head_data_nxt_s = head_data_r;
    head_last_nxt_s = head_last_r;
    tail_data_nxt_s = tail_data_r;
    tail_last_nxt_s = tail_last_r;
    case ({push_s, pop_s})
      2'b01: begin
        if (occ_r == 2'd2) begin
          head_data_nxt_s = tail_data_r;
          head_last_nxt_s = tail_last_r;
          occ_nxt_s       = 2'd1;
        end else begin
          occ_nxt_s = 2'd0;
        end
      end
      2'b10: begin
        if (occ_r == 2'd0) begin
          head_data_nxt_s = conv_data_s;
          head_last_nxt_s = last_s;
          occ_nxt_s       = 2'd1;
        end else if (occ_r == 2'd1) begin
          tail_data_nxt_s = conv_data_s;
          tail_last_nxt_s = last_s;
          occ_nxt_s       = 2'd2;
        end else begin
          // Full: ready is held low whenever a kept beat could arrive here.
          occ_nxt_s = occ_r;
        end
      end
      2'b11: begin
        // Pop first, then push; entry order is preserved.
        if (occ_r == 2'd2) begin
          head_data_nxt_s = tail_data_r;
          head_last_nxt_s = tail_last_r;
          tail_data_nxt_s = conv_data_s;
          tail_last_nxt_s = last_s;
          occ_nxt_s       = 2'd2;
        end else begin
          head_data_nxt_s = conv_data_s;
          head_last_nxt_s = last_s;
          occ_nxt_s       = 2'd1;
        end
      end
      default: begin
        occ_nxt_s = occ_r;
      end
    endcase
  end

  // Sticky saturation flag, set by any clipped kept sample.
  always_comb begin
    sat_nxt_s = sat_r | (push_s & conv_sat_s);
  end

  // Datapath and control registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      phase_r     <= PHASE_ZERO;
      frame_r     <= FRAME_ZERO;
      occ_r       <= 2'd0;
      head_data_r <= {MW{1'b0}};
      head_last_r <= 1'b0;
      tail_data_r <= {MW{1'b0}};
      tail_last_r <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      phase_r     <= phase_nxt_s;
      frame_r     <= frame_nxt_s;
      occ_r       <= occ_nxt_s;
      head_data_r <= head_data_nxt_s;
      head_last_r <= head_last_nxt_s;
      tail_data_r <= tail_data_nxt_s;
      tail_last_r <= tail_last_nxt_s;
      sat_r       <= sat_nxt_s;
    end
  end

  assign s_axis_data_tready = ready_s;
  assign m_axis_data_tvalid = (occ_r != 2'd0);
  assign m_axis_data_tdata  = head_data_r;
  assign m_axis_data_tlast  = head_last_r;
  assign sat_flag           = sat_r;

endmodule

// File: tb/tb_axis_decimator.sv
`timescale 1ns/1ps
// Self-checking bench for axis_decimator: a default instance (16->16,
// DECIM=6, FRAME_LEN=64) checked by a queue scoreboard, plus a narrowing
// instance (16->12, DECIM=1, FRAME_LEN=4) for saturation.
module tb_axis_decimator;

  localparam int DECIM     = 6;
  localparam int FRAME_LEN = 64;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_valid, s_ready, p_sync, m_ready, m_valid, m_last, sat;
  logic [15:0] s_data, m_data;
  logic        s2_valid, s2_ready, s2_sync, m2_ready, m2_valid, m2_last, sat2;
  logic [15:0] s2_data;
  logic [11:0] m2_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axis_decimator #(
    .C_S_AXIS_TDATA_WIDTH(16), .C_M_AXIS_TDATA_WIDTH(16),
    .DECIM(DECIM), .FRAME_LEN(FRAME_LEN)
  ) u_dut (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tvalid(s_valid), .s_axis_data_tdata(s_data),
    .s_axis_data_tready(s_ready), .phase_sync(p_sync),
    .m_axis_data_tready(m_ready), .m_axis_data_tvalid(m_valid),
    .m_axis_data_tdata(m_data), .m_axis_data_tlast(m_last),
    .sat_flag(sat)
  );

  axis_decimator #(
    .C_S_AXIS_TDATA_WIDTH(16), .C_M_AXIS_TDATA_WIDTH(12),
    .DECIM(1), .FRAME_LEN(4)
  ) u_dut_sat (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tvalid(s2_valid), .s_axis_data_tdata(s2_data),
    .s_axis_data_tready(s2_ready), .phase_sync(s2_sync),
    .m_axis_data_tready(m2_ready), .m_axis_data_tvalid(m2_valid),
    .m_axis_data_tdata(m2_data), .m_axis_data_tlast(m2_last),
    .sat_flag(sat2)
  );

  // Single comparison point.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: expected {last, data} entries not yet output.
  logic [16:0] exp_q[$];
  int          idx_since_sync = 0;
  int          kept_since_sync = 0;
  logic [15:0] log_data[$];
  logic        log_last[$];
  bit          chk_en = 1'b0;
  bit          acc_prev = 1'b0;
  bit          hold_v = 1'b0;
  logic [16:0] hold_val;
  logic [16:0] mon_e;
  bit          mon_rdy;
  int          ready_low_cnt = 0;
  int          acc_cnt = 0;
  int          max_q = 0;
  logic        rst_q = 1'b1;

  always @(posedge aclk) rst_q <= areset;

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge aclk);
      if (areset) begin
        exp_q.delete();
        idx_since_sync  = 0;
        kept_since_sync = 0;
        acc_prev        = 1'b0;
        hold_v          = 1'b0;
      end else if (chk_en) begin
        mon_rdy = !rst_q && ((exp_q.size() < 2) ||
                             (((idx_since_sync % DECIM) != 0) && !p_sync));
        check_val("s_ready", 32'(s_ready), 32'(mon_rdy));
        check_val("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        if (!s_ready && !rst_q) ready_low_cnt++;
        if (hold_v) check_val("hold_stable", {15'd0, m_last, m_data}, 32'(hold_val));
        if (m_valid && m_ready && (exp_q.size() != 0)) begin
          mon_e = exp_q.pop_front();
          check_val("out_data", 32'(m_data), 32'(mon_e[15:0]));
          check_val("out_last", 32'(m_last), 32'(mon_e[16]));
          log_data.push_back(m_data);
          log_last.push_back(m_last);
        end
        hold_v   = m_valid && !m_ready;
        hold_val = {m_last, m_data};
        if (s_valid && s_ready) begin
          if (p_sync) begin
            idx_since_sync  = 0;
            kept_since_sync = 0;
          end
          if ((idx_since_sync % DECIM) == 0) begin
            exp_q.push_back({((kept_since_sync % FRAME_LEN) == FRAME_LEN - 1), s_data});
            kept_since_sync++;
          end
          idx_since_sync++;
          acc_cnt++;
        end
        acc_prev = s_valid && s_ready;
        if (exp_q.size() > max_q) max_q = exp_q.size();
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1; s_valid = 1'b0; p_sync = 1'b0; m_ready = 1'b0;
    s2_valid = 1'b0; m2_ready = 1'b0;
    @(posedge aclk); @(negedge aclk);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", 32'(m_data), 32'd0);
    check_val("rst_m_last", 32'(m_last), 32'd0);
    check_val("rst_sat", 32'(sat), 32'd0);
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst2_m_valid", 32'(m2_valid), 32'd0);
    check_val("rst2_sat", 32'(sat2), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    log_data.delete();
    log_last.delete();
    @(negedge aclk);
    check_val("rdy_release_cycle", 32'(s_ready), 32'd0);
    chk_en = 1'b1;
    @(posedge aclk); @(negedge aclk);
    check_val("rdy_after_release", 32'(s_ready), 32'd1);
  endtask

  // Drive a ramp (or random data) until target beats are accepted.
  task automatic run_stream(input int target, input int max_cyc, input int vpct,
                            input int rpct, input int start_val, input int sync_val,
                            input int stall_at, input int stall_len, input bit rnd,
                            input bit drain);
    int cur;
    bit cur_sync;
    int start_acc;
    int c;
    cur       = rnd ? int'($urandom_range(65535)) : start_val;
    cur_sync  = !rnd && (cur == sync_val);
    start_acc = acc_cnt;
    c         = 0;
    while (((acc_cnt - start_acc) < target) && (c < max_cyc)) begin
      @(posedge aclk); #1;
      if (acc_prev) begin
        if (rnd) begin
          cur      = int'($urandom_range(65535));
          cur_sync = ($urandom_range(99) < 1);
        end else begin
          cur      = cur + 1;
          cur_sync = (cur == sync_val);
        end
      end
      s_data  = 16'(cur);
      p_sync  = cur_sync;
      s_valid = ($urandom_range(99) < vpct);
      m_ready = ((c >= stall_at) && (c < stall_at + stall_len)) ? 1'b0
                : ($urandom_range(99) < rpct);
      c++;
    end
    check_val("stream_done", 32'((acc_cnt - start_acc) >= target), 32'd1);
    if (drain) begin
      @(posedge aclk); #1;
      s_valid = 1'b0; p_sync = 1'b0; m_ready = 1'b1;
      repeat (8) @(posedge aclk);
      #1;
      check_val("drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  logic [15:0] sat_in  [6] = '{16'd2047, 16'hF800, 16'd2048, 16'h8000, 16'd1000, 16'hFFFB};
  logic [11:0] sat_exp [6] = '{12'h7FF, 12'h800, 12'h7FF, 12'h800, 12'd1000, 12'hFFB};
  logic        sat_lst [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        sat_flg [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int pos;
    int bad;
    areset = 1'b1; s_valid = 1'b0; s_data = 16'd0; p_sync = 1'b0; m_ready = 1'b0;
    s2_valid = 1'b0; s2_data = 16'd0; s2_sync = 1'b0; m2_ready = 1'b0;
    repeat (3) @(posedge aclk);
    do_reset();

    // Narrowing instance: saturation bounds, tlast every 4, sticky flag.
    @(posedge aclk); #1;
    m2_ready = 1'b1; s2_valid = 1'b1; s2_data = sat_in[0];
    for (int i = 0; i < 6; i++) begin
      check_val("sat_s_ready", 32'(s2_ready), 32'd1);
      @(posedge aclk); #1;
      check_val("sat_valid", 32'(m2_valid), 32'd1);
      check_val("sat_data", 32'(m2_data), 32'(sat_exp[i]));
      check_val("sat_last", 32'(m2_last), 32'(sat_lst[i]));
      check_val("sat_flag", 32'(sat2), 32'(sat_flg[i]));
      if (i < 5) s2_data = sat_in[i + 1];
      else s2_valid = 1'b0;
    end
    @(posedge aclk); #1;
    check_val("sat_idle_valid", 32'(m2_valid), 32'd0);
    check_val("sat_flag_sticky", 32'(sat2), 32'd1);

    // Plain ramp: every 6th value, tlast on outputs 64 and 128.
    run_stream(800, 2000, 100, 100, 0, -1, -1, 0, 1'b0, 1'b1);
    check_val("ramp_len", 32'(log_data.size() >= 128), 32'd1);
    if (log_data.size() >= 128) begin
      check_val("ramp_out0", 32'(log_data[0]), 32'd0);
      check_val("ramp_out1", 32'(log_data[1]), 32'd6);
      check_val("ramp_out64", 32'(log_data[63]), 32'd378);
      check_val("ramp_last64", 32'(log_last[63]), 32'd1);
      check_val("ramp_out128", 32'(log_data[127]), 32'd762);
      check_val("ramp_last128", 32'(log_last[127]), 32'd1);
      bad = 0;
      for (int i = 0; i < 128; i++) if (log_last[i]) bad++;
      check_val("ramp_last_count", 32'(bad), 32'd2);
    end

    // phase_sync on value 100 while phase is 3.
    do_reset();
    run_stream(600, 2000, 100, 100, 1, 100, -1, 0, 1'b0, 1'b1);
    pos = -1;
    for (int i = 0; i < log_data.size(); i++) if ((pos < 0) && (log_data[i] == 16'd100)) pos = i;
    check_val("sync_pos", 32'(pos), 32'd17);
    if ((pos > 0) && (log_data.size() > pos + 63)) begin
      check_val("sync_prev", 32'(log_data[pos - 1]), 32'd97);
      check_val("sync_next1", 32'(log_data[pos + 1]), 32'd106);
      check_val("sync_next2", 32'(log_data[pos + 2]), 32'd112);
      check_val("sync_out64", 32'(log_data[pos + 63]), 32'd478);
      check_val("sync_last64", 32'(log_last[pos + 63]), 32'd1);
      bad = 0;
      for (int i = 0; i < pos + 63; i++) if (log_last[i]) bad++;
      check_val("sync_early_last", 32'(bad), 32'd0);
    end

    // Downstream stall of 40 cycles on a continuous ramp.
    do_reset();
    ready_low_cnt = 0;
    max_q = 0;
    run_stream(400, 2000, 100, 100, 0, -1, 30, 40, 1'b0, 1'b1);
    check_val("stall_ready_low", 32'(ready_low_cnt >= 20), 32'd1);
    check_val("stall_max_occ", 32'(max_q), 32'd2);
    bad = 0;
    for (int i = 0; i < log_data.size(); i++) if (log_data[i] != 16'(6 * i)) bad++;
    check_val("stall_seq_gaps", 32'(bad), 32'd0);

    // Reset while the buffer holds two samples.
    do_reset();
    run_stream(10, 40, 100, 0, 301, -1, -1, 0, 1'b0, 1'b0);
    check_val("full_before_rst", 32'(exp_q.size()), 32'd2);
    check_val("head_before_rst", 32'(m_data), 32'd301);
    do_reset();
    run_stream(50, 200, 100, 100, 500, -1, -1, 0, 1'b0, 1'b1);
    check_val("restart_len", 32'(log_data.size() > 0), 32'd1);
    if (log_data.size() > 0) check_val("restart_first", 32'(log_data[0]), 32'd500);

    // Random valid/ready, 10k inputs, occasional sync.
    do_reset();
    run_stream(10000, 60000, 50, 50, 0, -1, -1, 0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
